// File: rtl/jtopl_pkg.sv
// Shared register map, slot descriptor and address decoders for the OPL register front-end.
package jtopl_pkg;

    localparam logic [7:0] REG_TEST  = 8'h01;
    localparam logic [7:0] REG_CLKA  = 8'h02;
    localparam logic [7:0] REG_CLKB  = 8'h03;
    localparam logic [7:0] REG_TIMER = 8'h04;
    localparam logic [7:0] REG_CSM   = 8'h08;
    localparam logic [7:0] REG_BD    = 8'hBD;
    localparam logic [7:0] REG_4OP   = 8'h04;
    localparam logic [7:0] REG_NEW   = 8'h05;

    typedef struct packed {
        logic       bank;
        logic [1:0] group;
        logic [2:0] sub;
    } opl_slot_t;

    typedef enum logic [3:0] {
        UP_NONE, UP_MULT, UP_KSL_TL, UP_AR_DR, UP_SL_RR,
        UP_WAV, UP_FNUMLO, UP_FNUMHI, UP_FBCON
    } upd_kind_t;

    typedef struct packed {
        upd_kind_t kind;
        opl_slot_t slot;
    } upd_t;

    // Operator registers: 0x20-0x9F and 0xE0-0xFF, slot 6/7 and group 3 are holes.
    function automatic upd_t op_decode(input logic [7:0] sel, input logic bank, input logic wav_ok);
        upd_t d;
        d.kind       = UP_NONE;
        d.slot.bank  = bank;
        d.slot.group = sel[4:3];
        d.slot.sub   = sel[2:0];
        if ((sel[2:0] <= 3'd5) && (sel[4:3] != 2'd3)) begin
            case (sel[7:5])
                3'd1:    d.kind = UP_MULT;
                3'd2:    d.kind = UP_KSL_TL;
                3'd3:    d.kind = UP_AR_DR;
                3'd4:    d.kind = UP_SL_RR;
                3'd7:    d.kind = wav_ok ? UP_WAV : UP_NONE;
                default: d.kind = UP_NONE;
            endcase
        end else begin
            d.kind = UP_NONE;
        end
        return d;
    endfunction

    // Channel registers: 0xA0-0xC8, channel n maps to group n/3 and sub n or n-6.
    function automatic upd_t ch_decode(input logic [7:0] sel, input logic bank);
        upd_t       d;
        logic [3:0] n;
        n            = sel[3:0];
        d.kind       = UP_NONE;
        d.slot.bank  = bank;
        d.slot.group = (n < 4'd3) ? 2'd0 : ((n < 4'd6) ? 2'd1 : 2'd2);
        d.slot.sub   = (n < 4'd6) ? n[2:0] : 3'(n - 4'd6);
        if (n <= 4'd8) begin
            case (sel[7:4])
                4'hA:    d.kind = UP_FNUMLO;
                4'hB:    d.kind = UP_FNUMHI;
                4'hC:    d.kind = UP_FBCON;
                default: d.kind = UP_NONE;
            endcase
        end else begin
            d.kind = UP_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/jtopl_busy.sv
// Chip write-busy counter: loads on an accepted write, counts down on chip clock enables.
module jtopl_busy #(
    parameter int unsigned BUSY_ADDR = 32'd12,
    parameter int unsigned BUSY_DATA = 32'd84
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic is_data,
    input  logic tick,
    output logic busy
);

    localparam int unsigned MAXV = (BUSY_ADDR > BUSY_DATA) ? BUSY_ADDR : BUSY_DATA;
    localparam int unsigned CW   = (MAXV < 32'd2) ? 32'd1 : $clog2(MAXV + 32'd1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;

    // Next count: a fresh write reloads even if a tick arrives in the same cycle.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = is_data ? CW'(BUSY_DATA) : CW'(BUSY_ADDR);
        end else if (tick && (cnt_r != {CW{1'b0}})) begin
            cnt_nxt_s = cnt_r - CW'(32'd1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            busy  <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            busy  <= (cnt_nxt_s != {CW{1'b0}});
        end
    end

endmodule

// File: rtl/jtopl_mmr_bank.sv
// CPU register front-end for OPL-family cores with an optional second (OPL3) bank.
// Turns address/data writes into slot update strobes and global control registers.
module jtopl_mmr_bank
    import jtopl_pkg::*;
#(
    parameter int unsigned OPL_TYPE  = 32'd3,
    parameter int unsigned NBANK     = 32'd2,
    parameter int unsigned BUSY_ADDR = 32'd12,
    parameter int unsigned BUSY_DATA = 32'd84
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cenop,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic       busy,
    output logic       sel_bank,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic [7:0] din_copy,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       wave_mode,
    output logic       csm_en,
    output logic       note_sel,
    output logic       new_mode,
    output logic [5:0] con4op
);

    localparam logic HAS_BANK1 = (NBANK > 32'd1) && (OPL_TYPE == 32'd3);
    localparam logic WAV_OK    = (OPL_TYPE >= 32'd2);

    logic       accept_s;
    logic       addr_wr_s;
    logic       data_wr_s;
    logic       ignore_s;
    logic [7:0] selreg_r;
    logic       selbank_r;
    upd_t       op_s;
    upd_t       ch_s;
    upd_t       dec_s;
    upd_t       pend_r;
    logic       pend_valid_r;
    logic [7:0] strobe_s;
    logic [7:0] up_r;

    assign accept_s  = write & ~busy;
    assign addr_wr_s = accept_s & ~addr[0];
    assign data_wr_s = accept_s & addr[0];

    jtopl_busy #(
        .BUSY_ADDR (BUSY_ADDR),
        .BUSY_DATA (BUSY_DATA)
    ) u_busy (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_s),
        .is_data (addr[0]),
        .tick    (cen),
        .busy    (busy)
    );

    // Decode of the latched register; bank-1 writes outside 0x04/0x05 vanish in compatibility mode.
    always_comb begin
        op_s     = op_decode(selreg_r, selbank_r, WAV_OK);
        ch_s     = ch_decode(selreg_r, selbank_r);
        ignore_s = selbank_r & ~new_mode & (selreg_r != REG_4OP) & (selreg_r != REG_NEW);
        dec_s    = op_s;
        if (ignore_s) begin
            dec_s.kind = UP_NONE;
        end else if (op_s.kind == UP_NONE) begin
            dec_s = ch_s;
        end else begin
            dec_s = op_s;
        end
    end

    // One-hot strobe pattern for the pending update.
    always_comb begin
        strobe_s = 8'h00;
        case (pend_r.kind)
            UP_MULT:   strobe_s = 8'h01;
            UP_KSL_TL: strobe_s = 8'h02;
            UP_AR_DR:  strobe_s = 8'h04;
            UP_SL_RR:  strobe_s = 8'h08;
            UP_WAV:    strobe_s = 8'h10;
            UP_FNUMLO: strobe_s = 8'h20;
            UP_FNUMHI: strobe_s = 8'h40;
            UP_FBCON:  strobe_s = 8'h80;
            default:   strobe_s = 8'h00;
        endcase
    end

    // Address latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selreg_r  <= 8'h00;
            selbank_r <= 1'b0;
        end else if (addr_wr_s) begin
            selreg_r  <= din;
            selbank_r <= HAS_BANK1 ? addr[1] : 1'b0;
        end
    end

    // Data capture: strobes drop on the write and the decoded one rises a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_copy     <= 8'h00;
            up_r         <= 8'h00;
            pend_r.kind  <= UP_NONE;
            pend_r.slot  <= 6'd0;
            pend_valid_r <= 1'b0;
            sel_bank     <= 1'b0;
            sel_group    <= 2'd0;
            sel_sub      <= 3'd0;
        end else if (data_wr_s) begin
            din_copy     <= din;
            up_r         <= 8'h00;
            pend_r       <= dec_s;
            pend_valid_r <= 1'b1;
        end else if (pend_valid_r) begin
            pend_valid_r <= 1'b0;
            up_r         <= strobe_s;
            if (pend_r.kind != UP_NONE) begin
                {sel_bank, sel_group, sel_sub} <= pend_r.slot;
            end
        end
    end

    assign {up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} = up_r;

    // Global registers; timer load/flag-clear bits self-clear on an idle operator tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_A    <= 8'h00;
            value_B    <= 8'h00;
            load_A     <= 1'b1;
            load_B     <= 1'b1;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            flagen_A   <= 1'b1;
            flagen_B   <= 1'b1;
            am_dep     <= 1'b0;
            vib_dep    <= 1'b0;
            rhy_en     <= 1'b0;
            rhy_kon    <= 5'd0;
            wave_mode  <= 1'b0;
            csm_en     <= 1'b0;
            note_sel   <= 1'b0;
            new_mode   <= 1'b0;
            con4op     <= 6'd0;
        end else if (data_wr_s && !ignore_s) begin
            if (!selbank_r) begin
                case (selreg_r)
                    REG_TEST: wave_mode <= WAV_OK ? din[5] : 1'b0;
                    REG_CLKA: value_A <= din;
                    REG_CLKB: value_B <= din;
                    REG_TIMER: begin
                        if (din[7]) begin
                            clr_flag_A <= 1'b1;
                            clr_flag_B <= 1'b1;
                        end else begin
                            flagen_A <= ~din[6];
                            flagen_B <= ~din[5];
                            load_A   <= ~din[0];
                            load_B   <= ~din[1];
                        end
                    end
                    REG_CSM: begin
                        csm_en   <= din[7];
                        note_sel <= din[6];
                    end
                    REG_BD:  {am_dep, vib_dep, rhy_en, rhy_kon} <= din;
                    default: ;
                endcase
            end else begin
                case (selreg_r)
                    REG_4OP: con4op <= din[5:0];
                    REG_NEW: begin
                        new_mode <= din[0];
                        if (!din[0]) begin
                            con4op <= 6'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (cenop && !accept_s) begin
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            load_A     <= 1'b1;
            load_B     <= 1'b1;
        end
    end

endmodule
